// File: rtl/conv_decoder_pkg.sv
// Shared constants for the conv decoder output path: default pixel format,
// saturation bounds and the accumulator state encoding.
package conv_decoder_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int FRAC_W_DEF = 9;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_FINAL = 1'b1;

  function automatic int ch_cnt_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/conv_decoder_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head; the head holds
// its last value while the FIFO is empty.
module conv_decoder_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold_q : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments in every clocked block so all flops update
  // from pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count_q,
  // and leaving the array reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/conv_decoder_channel_accumulator.sv
// Sums NUM_CH per-channel partial pixels plus bias, saturates, applies optional
// ReLU and queues the finished pixel; back-pressures the PE array on the last channel.
module conv_decoder_channel_accumulator
  import conv_decoder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int NUM_CH     = 16,
  parameter int ACC_W      = DATA_W + $clog2(NUM_CH) + 1,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = ch_cnt_width(NUM_CH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic [DATA_W-1:0] bias,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic [CH_W-1:0]   ch_cnt,
  output logic              sat_seen
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [0:0]              state_q, state_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_seen_q, sat_seen_d;

  logic                    accept;
  logic                    last_ch;
  logic                    push;
  logic                    pop;
  logic signed [ACC_W-1:0] res_wide;
  logic signed [ACC_W-1:0] pixel_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        unused_fifo_count;

  assign last_ch   = (ch_cnt_q == LAST_CH);
  assign pixel_ext = ACC_W'($signed(in_pixel));
  assign bias_ext  = ACC_W'($signed(bias));

  // Only the closing channel needs a free FIFO slot, so FINAL can always push.
  assign in_ready  = (state_q == ST_ACCUM) && !(last_ch && fifo_full);
  assign accept    = in_valid && in_ready;

  assign out_valid = !fifo_empty;
  assign pop       = out_ready && !fifo_empty;
  assign ch_cnt    = ch_cnt_q;
  assign sat_seen  = sat_seen_q;

  always_comb begin
    state_d    = state_q;
    ch_cnt_d   = ch_cnt_q;
    acc_d      = acc_q;
    sat_seen_d = sat_seen_q;
    push       = 1'b0;
    res_wide   = acc_q;
    if (state_q == ST_FINAL) begin
      if (acc_q > SAT_HI) begin
        res_wide   = SAT_HI;
        sat_seen_d = 1'b1;
      end else if (acc_q < SAT_LO) begin
        res_wide   = SAT_LO;
        sat_seen_d = 1'b1;
      end
      // ReLU is applied after saturation and never counts as a saturation event.
      if (relu_en && res_wide[ACC_W-1]) res_wide = '0;
      push    = 1'b1;
      state_d = ST_ACCUM;
    end else if (accept) begin
      acc_d = (ch_cnt_q == '0) ? (pixel_ext + bias_ext) : (acc_q + pixel_ext);
      if (last_ch) begin
        ch_cnt_d = '0;
        state_d  = ST_FINAL;
      end else begin
        ch_cnt_d = ch_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ACCUM;
      ch_cnt_q   <= '0;
      acc_q      <= '0;
      sat_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_cnt_q   <= ch_cnt_d;
      acc_q      <= acc_d;
      sat_seen_q <= sat_seen_d;
    end
  end

  conv_decoder_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (res_wide[DATA_W-1:0]),
    .dout  (out_pixel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

endmodule

// File: tb/tb_conv_decoder_channel_accumulator.sv
// Directed and randomized bench for the channel accumulator, checked each cycle
// against an arithmetic reference model of sums, saturation, ReLU and FIFO order.
module tb_conv_decoder_channel_accumulator;

  localparam int DATA_W     = 18;
  localparam int NUM_CH     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel = '0;
  logic [DATA_W-1:0] bias = '0;
  logic              relu_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_pixel;
  logic [CH_W-1:0]   ch_cnt;
  logic              sat_seen;

  conv_decoder_channel_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .ch_cnt    (ch_cnt),
    .sat_seen  (sat_seen)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errs   = 0;
  int     n_pops   = 0;
  int     exp_q[$];
  int     m_ch     = 0;
  longint m_sum    = 0;
  bit     m_final  = 1'b0;
  bit     m_sat    = 1'b0;
  bit     rand_or  = 1'b0;
  int     vals[NUM_CH];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_result(input longint s, input bit relu, output bit sat);
    int r;
    sat = 1'b0;
    if (s > 131071) begin
      r = 131071; sat = 1'b1;
    end else if (s < -131072) begin
      r = -131072; sat = 1'b1;
    end else begin
      r = int'(s);
    end
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic cyc(output bit accepted);
    bit exp_ready;
    bit s;
    int pix;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_ready = !m_final && !(m_ch == NUM_CH - 1 && exp_q.size() == FIFO_DEPTH);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("ch_cnt", ch_cnt, m_ch);
    check("sat_seen", sat_seen, m_sat);
    if (exp_q.size() != 0) begin
      check("out_pixel", $signed(out_pixel), exp_q[0]);
      if (out_ready) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
    end
    accepted = in_valid && exp_ready;
    if (m_final) begin
      exp_q.push_back(model_result(m_sum, relu_en, s));
      m_sat   = m_sat | s;
      m_final = 1'b0;
    end else if (accepted) begin
      pix   = int'($signed(in_pixel));
      m_sum = (m_ch == 0) ? longint'(pix) + longint'(int'($signed(bias))) : m_sum + pix;
      if (m_ch == NUM_CH - 1) begin
        m_ch    = 0;
        m_final = 1'b1;
      end else begin
        m_ch++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_ch(input int v, input int b);
    bit a = 1'b0;
    in_pixel = DATA_W'(v);
    bias     = DATA_W'(b);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      cyc(a);
      if (a) break;
    end
    if (!a) check("accept_timeout", a, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_pixel(input int b);
    for (int c = 0; c < NUM_CH; c++) send_ch(vals[c], b);
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !m_final) break;
      cyc(a);
    end
    check("drain_empty", exp_q.size() + int'(m_final), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_ch = 0; m_sum = 0; m_final = 1'b0; m_sat = 1'b0;
    rst = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_ch_cnt", ch_cnt, 0);
    check("rst_sat_seen", sat_seen, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    bit a;
    int pops0;

    do_reset();

    // 1: sixteen channels of 1.0 plus bias 0.5
    out_ready = 1'b1;
    relu_en   = 1'b0;
    foreach (vals[i]) vals[i] = 512;
    send_pixel(256);
    check("t1_ov_in_final", out_valid, 0);
    cyc(a);
    check("t1_ov", out_valid, 1);
    check("t1_px", $signed(out_pixel), 8448);
    check("t1_sat", sat_seen, 0);
    cyc(a);

    // 2: positive and negative saturation
    foreach (vals[i]) vals[i] = 20000;
    send_pixel(0);
    cyc(a);
    check("t2_px_pos", $signed(out_pixel), 131071);
    check("t2_sat", sat_seen, 1);
    cyc(a);
    foreach (vals[i]) vals[i] = -20000;
    send_pixel(0);
    cyc(a);
    check("t2_px_neg", $signed(out_pixel), -131072);
    cyc(a);

    // 3: ReLU clamps without marking saturation
    do_reset();
    out_ready = 1'b1;
    relu_en   = 1'b1;
    foreach (vals[i]) vals[i] = 0;
    vals[0] = -1000;
    send_pixel(0);
    cyc(a);
    check("t3_relu_px", $signed(out_pixel), 0);
    check("t3_relu_sat", sat_seen, 0);
    cyc(a);
    relu_en = 1'b0;
    send_pixel(0);
    cyc(a);
    check("t3_norelu_px", $signed(out_pixel), -1000);
    cyc(a);

    // 4/5: fill FIFO, stall the closing channel of pixel 9, then release
    out_ready = 1'b0;
    pops0 = n_pops;
    for (int p = 0; p < 8; p++) begin
      foreach (vals[i]) vals[i] = int'($urandom_range(0, 2000)) - 1000;
      send_pixel(p * 37 - 100);
    end
    foreach (vals[i]) vals[i] = int'($urandom_range(0, 2000)) - 1000;
    for (int c = 0; c < NUM_CH - 1; c++) send_ch(vals[c], 55);
    in_pixel = DATA_W'(vals[NUM_CH-1]);
    bias     = DATA_W'(55);
    in_valid = 1'b1;
    repeat (3) cyc(a);
    check("t4_stall_ready", in_ready, 0);
    check("t4_stall_ch", ch_cnt, NUM_CH - 1);
    out_ready = 1'b1;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) cyc(a);
    check("t4_last_accepted", a, 1);
    in_valid = 1'b0;
    drain();
    check("t4_pop_count", n_pops - pops0, 9);

    // 6: reset mid-pixel drops stale partials
    foreach (vals[i]) vals[i] = 5000;
    for (int c = 0; c < 7; c++) send_ch(vals[c], 300);
    check("t6_pre_ch", ch_cnt, 7);
    do_reset();
    out_ready = 1'b1;
    foreach (vals[i]) vals[i] = 100;
    send_pixel(0);
    cyc(a);
    check("t6_px", $signed(out_pixel), 1600);
    check("t6_sat", sat_seen, 0);
    cyc(a);

    // Random traffic with random back-pressure, ReLU and idle gaps
    rand_or = 1'b1;
    for (int p = 0; p < 30; p++) begin
      relu_en = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) cyc(a);
        send_ch(int'($urandom_range(0, 80000)) - 40000,
                int'($urandom_range(0, 262143)) - 131072);
      end
    end
    rand_or   = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
